execute_stage: RTL and testbench

- Execute stage directly downstream of the decode/execute pipeline register.
- Consumes the decoded control bits and operands, performs the ALU operation, and registers results and pass-through control into the execute/memory boundary.
- Implements multiply iteratively by default, stalling upstream while it runs.
- Honours downstream stall and pipeline flush.

---
 rtl/execute_stage.sv | 195 +++++++++++++++++++
 tb/tb_execute_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage: operand muxing, ALU, iterative shift-add multiplier and the
// EX/MEM output register with pass-through control fields.
// Optional build macro EXEC_FAST_MUL_EN: when defined, ALUop 111 is a
// single-cycle combinational multiply and the multiplier FSM stays in IDLE.
//
// Handshake: stall_out=1 tells the ID/EX register to hold its contents; an
// instruction presented on the inputs is consumed on a posedge where stall_out
// is 0. stall_in=1 from downstream freezes the output register (it keeps
// presenting the same result), and flush_in squashes whatever EX holds.
module execute_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wbs_in,
    input  logic              mm_in,
    input  logic [2:0]        ALUop_in,
    input  logic              wm_in,
    input  logic              am_in,
    input  logic              ni_in,
    input  logic              wme_in,
    input  logic              alu_mux_in,
    input  logic              alu_mux1_in,
    input  logic [REG_W-1:0]  reg_dest_in,
    input  logic [DATA_W-1:0] srcA_in,
    input  logic [DATA_W-1:0] srcB_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [DATA_W-1:0] fwd_in,
    input  logic              stall_in,
    input  logic              flush_in,
    output logic              stall_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] result_out,
    output logic [DATA_W-1:0] store_data_out,
    output logic              zero_out,
    output logic              neg_out,
    output logic              wbs_out,
    output logic              mm_out,
    output logic              wm_out,
    output logic              am_out,
    output logic              wme_out,
    output logic [REG_W-1:0]  reg_dest_out
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, MUL_BUSY, MUL_DONE} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  a_op, b_op, alu_res, load_res;
    logic [DATA_W-1:0]  mul_a_q, mul_b_q, mul_acc_q;
    logic [CNT_W-1:0]   mul_cnt_q;
    logic               start, ld_en, ld_bubble, mul_step;

    assign a_op = alu_mux1_in ? fwd_in : srcA_in;
    assign b_op = alu_mux_in  ? imm_in : srcB_in;

`ifdef EXEC_FAST_MUL_EN
    assign start = 1'b0;
`else
    assign start = (state_q == IDLE) && (ALUop_in == 3'b111) && !ni_in
                   && !stall_in && !flush_in;
`endif

    // ALU result for the instruction currently presented by ID/EX
    always_comb begin
        alu_res = '0;
        case (ALUop_in)
            3'b000: alu_res = a_op + b_op;
            3'b001: alu_res = a_op - b_op;
            3'b010: alu_res = a_op & b_op;
            3'b011: alu_res = a_op | b_op;
            3'b100: alu_res = a_op ^ b_op;
            3'b101: alu_res = a_op << b_op[3:0];
            3'b110: alu_res = a_op >> b_op[3:0];
`ifdef EXEC_FAST_MUL_EN
            default: alu_res = a_op * b_op;
`else
            // the iterative path supplies the product; start cycle loads a bubble
            default: alu_res = '0;
`endif
        endcase
    end

    // Next state, output-register load control and upstream stall
    always_comb begin
        state_d   = state_q;
        ld_en     = 1'b0;
        ld_bubble = 1'b0;
        load_res  = alu_res;
        mul_step  = 1'b0;
        stall_out = stall_in;
        case (state_q)
            IDLE: begin
                stall_out = stall_in | start;
                if (start) begin
                    ld_en     = 1'b1;
                    ld_bubble = 1'b1;
                    state_d   = MUL_BUSY;
                end else if (!stall_in) begin
                    ld_en     = 1'b1;
                    ld_bubble = ni_in;
                end
            end
            MUL_BUSY: begin
                stall_out = 1'b1;
                mul_step  = 1'b1;
                if (mul_cnt_q == CNT_W'(DATA_W - 1)) state_d = MUL_DONE;
            end
            MUL_DONE: begin
                load_res = mul_acc_q;
                if (!stall_in) begin
                    ld_en   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // a flush overrides stall and FSM: squash EX and drop any multiply
        if (flush_in) begin
            state_d   = IDLE;
            ld_en     = 1'b1;
            ld_bubble = 1'b1;
            mul_step  = 1'b0;
            stall_out = stall_in;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Shift-add multiplier: add A when B's LSB is set, then shift A up and B down
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            mul_acc_q <= '0;
            mul_cnt_q <= '0;
        end else if (start) begin
            mul_a_q   <= a_op;
            mul_b_q   <= b_op;
            mul_acc_q <= '0;
            mul_cnt_q <= '0;
        end else if (mul_step) begin
            mul_acc_q <= mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);
            mul_a_q   <= mul_a_q << 1;
            mul_b_q   <= mul_b_q >> 1;
            mul_cnt_q <= mul_cnt_q + 1'b1;
        end
    end

    // EX/MEM output register; bubbles clear valid and all control fields
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out      <= 1'b0;
            result_out     <= '0;
            store_data_out <= '0;
            zero_out       <= 1'b0;
            neg_out        <= 1'b0;
            wbs_out        <= 1'b0;
            mm_out         <= 1'b0;
            wm_out         <= 1'b0;
            am_out         <= 1'b0;
            wme_out        <= 1'b0;
            reg_dest_out   <= '0;
        end else if (ld_en) begin
            result_out     <= load_res;
            store_data_out <= srcB_in;
            zero_out       <= (load_res == '0);
            neg_out        <= load_res[DATA_W-1];
            if (ld_bubble) begin
                valid_out    <= 1'b0;
                wbs_out      <= 1'b0;
                mm_out       <= 1'b0;
                wm_out       <= 1'b0;
                am_out       <= 1'b0;
                wme_out      <= 1'b0;
                reg_dest_out <= '0;
            end else begin
                valid_out    <= 1'b1;
                wbs_out      <= wbs_in;
                mm_out       <= mm_in;
                wm_out       <= wm_in;
                am_out       <= am_in;
                wme_out      <= wme_in;
                reg_dest_out <= reg_dest_in;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases, random ALU ops,
// stall/flush/reset interaction, scoreboard of expected EX/MEM contents.
module tb_execute_stage;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;
    localparam int EXP_W  = 5 + REG_W + DATA_W + DATA_W + 2;

`ifdef EXEC_FAST_MUL_EN
    localparam int MUL_LAT = 1;
    localparam int MUL_ST  = 0;
`else
    localparam int MUL_LAT = 18;
    localparam int MUL_ST  = 17;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic wbs_in, mm_in, wm_in, am_in, ni_in, wme_in, alu_mux_in, alu_mux1_in;
    logic [2:0] ALUop_in;
    logic [REG_W-1:0] reg_dest_in;
    logic [DATA_W-1:0] srcA_in, srcB_in, imm_in, fwd_in;
    logic stall_in, flush_in;
    logic stall_out, valid_out, zero_out, neg_out;
    logic [DATA_W-1:0] result_out, store_data_out;
    logic wbs_out, mm_out, wm_out, am_out, wme_out;
    logic [REG_W-1:0] reg_dest_out;

    logic [EXP_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    execute_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wbs_in(wbs_in), .mm_in(mm_in), .ALUop_in(ALUop_in), .wm_in(wm_in),
        .am_in(am_in), .ni_in(ni_in), .wme_in(wme_in),
        .alu_mux_in(alu_mux_in), .alu_mux1_in(alu_mux1_in),
        .reg_dest_in(reg_dest_in), .srcA_in(srcA_in), .srcB_in(srcB_in),
        .imm_in(imm_in), .fwd_in(fwd_in), .stall_in(stall_in), .flush_in(flush_in),
        .stall_out(stall_out), .valid_out(valid_out), .result_out(result_out),
        .store_data_out(store_data_out), .zero_out(zero_out), .neg_out(neg_out),
        .wbs_out(wbs_out), .mm_out(mm_out), .wm_out(wm_out), .am_out(am_out),
        .wme_out(wme_out), .reg_dest_out(reg_dest_out)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model(input logic [2:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [3:0] sh;
        sh = b[3:0];
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << sh;
            3'd6: return a >> sh;
            default: return a * b;
        endcase
    endfunction

    task automatic compare_out();
        logic [EXP_W-1:0] e;
        e = exp_q.pop_front();
        check("ctrl", {wbs_out, mm_out, wm_out, am_out, wme_out}, e[EXP_W-1 -: 5]);
        check("reg_dest", reg_dest_out, e[EXP_W-6 -: REG_W]);
        check("result", result_out, e[2*DATA_W+1 -: DATA_W]);
        check("store_data", store_data_out, e[DATA_W+1 -: DATA_W]);
        check("zero", zero_out, e[1]);
        check("neg", neg_out, e[0]);
    endtask

    task automatic set_idle();
        ni_in = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
    endtask

    task automatic present(input logic [2:0] op, input logic [DATA_W-1:0] a, b,
                           input logic sel_imm, input logic [DATA_W-1:0] imm,
                           input logic sel_fwd, input logic [DATA_W-1:0] fwd,
                           input logic [REG_W-1:0] rd, input logic [4:0] ctrl);
        ALUop_in = op; srcA_in = a; srcB_in = b; imm_in = imm; fwd_in = fwd;
        alu_mux_in = sel_imm; alu_mux1_in = sel_fwd; reg_dest_in = rd;
        {wbs_in, mm_in, wm_in, am_in, wme_in} = ctrl;
        ni_in = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
    endtask

    // drive one instruction, push its expected outputs, wait for it to retire
    task automatic exec_op(input logic [2:0] op, input logic [DATA_W-1:0] a, b,
                           input logic sel_imm, input logic [DATA_W-1:0] imm,
                           input logic sel_fwd, input logic [DATA_W-1:0] fwd,
                           input logic [REG_W-1:0] rd, input logic [4:0] ctrl);
        logic [DATA_W-1:0] res;
        logic z;
        int n_cyc, n_st;
        bit got;
        res = model(op, sel_fwd ? fwd : a, sel_imm ? imm : b);
        z = (res == '0);
        present(op, a, b, sel_imm, imm, sel_fwd, fwd, rd, ctrl);
        exp_q.push_back({ctrl, rd, res, b, z, res[DATA_W-1]});
        n_cyc = 0; n_st = 0; got = 0;
        while (!got && n_cyc < 40) begin
            #1;
            if (stall_out) n_st++;
            @(negedge clk);
            n_cyc++;
            if (valid_out) got = 1;
        end
        set_idle();
        check("valid_seen", got, 1);
        check("latency", n_cyc, (op == 3'b111) ? MUL_LAT : 1);
        check("stall_cycles", n_st, (op == 3'b111) ? MUL_ST : 0);
        if (got) compare_out();
        else void'(exp_q.pop_front());
    endtask

    task automatic expect_no_valid(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid_out) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        present(3'b000, '0, '0, 1'b0, '0, 1'b0, '0, '0, 5'b0);
        set_idle();
        repeat (2) @(negedge clk);
        check("rst_valid", valid_out, 0);
        check("rst_result", result_out, 0);
        check("rst_store", store_data_out, 0);
        check("rst_flags", {zero_out, neg_out}, 0);
        check("rst_ctrl", {wbs_out, mm_out, wm_out, am_out, wme_out, reg_dest_out}, 0);
        rst_n = 1'b1;
        #1 check("rst_stall", stall_out, 0);
        @(negedge clk);

        // directed cases
        exec_op(3'b000, 16'h0003, 16'h0004, 0, 16'h0, 0, 16'h0, 4'd5, 5'b00100);
        exec_op(3'b001, 16'h0005, 16'h1234, 1, 16'h0005, 0, 16'h0, 4'd2, 5'b10001);
        exec_op(3'b001, 16'h0001, 16'h0002, 0, 16'h0, 0, 16'h0, 4'd7, 5'b01010);
        exec_op(3'b101, 16'h0001, 16'h0013, 0, 16'h0, 1, 16'h8001, 4'd1, 5'b11111);
        exec_op(3'b110, 16'h8000, 16'h000F, 0, 16'h0, 0, 16'h0, 4'd9, 5'b00110);
        exec_op(3'b111, 16'h0012, 16'h0034, 0, 16'h0, 0, 16'h0, 4'd4, 5'b00100);
        exec_op(3'b111, 16'h0100, 16'h0100, 0, 16'h0, 0, 16'h0, 4'd6, 5'b01100);

        // downstream stall holds the output register
        exec_op(3'b000, 16'h0010, 16'h0020, 0, 16'h0, 0, 16'h0, 4'd3, 5'b00100);
        present(3'b011, 16'h00F0, 16'h000F, 0, 16'h0, 0, 16'h0, 4'd8, 5'b00100);
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_stall_out", stall_out, 1);
            @(negedge clk);
            check("hold_result", result_out, 16'h0030);
            check("hold_valid", valid_out, 1);
            check("hold_dest", reg_dest_out, 4'd3);
        end
        exec_op(3'b011, 16'h00F0, 16'h000F, 0, 16'h0, 0, 16'h0, 4'd8, 5'b00100);

        // stall and flush together: flush wins, bubble loads
        present(3'b000, 16'h0001, 16'h0001, 0, 16'h0, 0, 16'h0, 4'd2, 5'b11111);
        stall_in = 1'b1; flush_in = 1'b1;
        #1 check("sf_stall_out", stall_out, 1);
        @(negedge clk);
        set_idle();
        check("sf_valid", valid_out, 0);
        check("sf_ctrl", {wbs_out, mm_out, wm_out, am_out, wme_out}, 0);

`ifndef EXEC_FAST_MUL_EN
        // stall while the product waits in MUL_DONE
        present(3'b111, 16'h0012, 16'h0034, 0, 16'h0, 0, 16'h0, 4'd11, 5'b00101);
        exp_q.push_back({5'b00101, 4'd11, 16'h03A8, 16'h0034, 1'b0, 1'b0});
        repeat (17) @(negedge clk);
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("done_stall_out", stall_out, 1);
            @(negedge clk);
            check("done_hold_valid", valid_out, 0);
        end
        stall_in = 1'b0;
        #1 check("done_release_stall", stall_out, 0);
        @(negedge clk);
        set_idle();
        check("done_valid", valid_out, 1);
        compare_out();

        // flush at busy step 5 discards the multiply
        present(3'b111, 16'h0012, 16'h0034, 0, 16'h0, 0, 16'h0, 4'd1, 5'b00100);
        repeat (6) @(negedge clk);
        flush_in = 1'b1;
        #1 check("flush_stall_out", stall_out, 0);
        @(negedge clk);
        set_idle();
        check("flush_valid", valid_out, 0);
        #1 check("flush_idle_stall", stall_out, 0);
        expect_no_valid("flush_no_product", 20);

        // reset mid-multiply aborts it
        present(3'b111, 16'h0012, 16'h0034, 0, 16'h0, 0, 16'h0, 4'd1, 5'b00100);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        check("mrst_valid", valid_out, 0);
        check("mrst_result", result_out, 0);
        check("mrst_store", store_data_out, 0);
        check("mrst_ctrl", {wbs_out, mm_out, wm_out, am_out, wme_out, reg_dest_out}, 0);
        rst_n = 1'b1;
        #1 check("mrst_stall", stall_out, 0);
        expect_no_valid("mrst_no_product", 20);
`endif

        // random operations through every operand path
        for (int i = 0; i < 24; i++) begin
            exec_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 1)), 16'($urandom),
                    1'($urandom_range(0, 1)), 16'($urandom),
                    4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
        end

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
